nou_rsp_fifo: RTL

- Response FIFO directly downstream of the NOU retire stage.
- Buffers completed-response commands (XOCC command format) written by retire.
- Presents them to the RISC-V core's response read port as a first-word-fall-through valid/ready stream.
- Reports full back to retire so that retire holds its source units (keep) instead of losing responses.

---
 rtl/nou_rsp_fifo_pkg.sv | 17 +
 rtl/nou_sync_fifo.sv | 53 +++++
 rtl/nou_rsp_fifo.sv | 97 +++++++++
 3 files changed

// File: rtl/nou_rsp_fifo_pkg.sv
// Shared NOU response-path constants; defines NOU_XOCC_CMD_WIDTH if absent.
// Doubles as the nou_define.h content so every design file sees one source.
`ifndef NOU_XOCC_CMD_WIDTH
`define NOU_XOCC_CMD_WIDTH 32
`endif

package nou_rsp_fifo_pkg;

  localparam int NOU_RSP_DEPTH = 8;
  localparam int NOU_RSP_AFULL = NOU_RSP_DEPTH - 2;

  // Pointer/count width: index bits plus one wrap bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nou_sync_fifo.sv
// Generic synchronous FIFO: storage, wrap-bit pointers, full/empty/cnt.
// Push is ignored while full and pop is ignored while empty.
module nou_sync_fifo
  import nou_rsp_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = cnt_w(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);
  assign cnt   = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; valid data is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/nou_rsp_fifo.sv
// Retire-to-core response FIFO: FWFT stream, afull, sticky ovf.
// Optional interrupt on occupancy/overflow under NOU_RSP_FIFO_IRQ_EN.
module nou_rsp_fifo
  import nou_rsp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = `NOU_XOCC_CMD_WIDTH,
  parameter int DEPTH      = NOU_RSP_DEPTH,
`ifdef NOU_RSP_FIFO_IRQ_EN
  parameter int IRQ_THRESH = 1,
`endif
  parameter int AFULL_LVL  = DEPTH - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    retire_rsp_fifo_wr_en,
  input  logic [DATA_WIDTH-1:0]   retire_rsp_fifo_data,
  output logic                    rsp_fifo_retire_full,
  output logic                    rsp_fifo_rv_vld,
  output logic [DATA_WIDTH-1:0]   rsp_fifo_rv_data,
  input  logic                    rv_rsp_fifo_rdy,
  output logic [cnt_w(DEPTH)-1:0] rsp_fifo_cnt,
  output logic                    rsp_fifo_afull,
`ifdef NOU_RSP_FIFO_IRQ_EN
  input  logic                    rv_rsp_fifo_irq_clr,
  output logic                    rsp_fifo_rv_irq,
`endif
  output logic                    rsp_fifo_ovf
);

  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] AF_LVL = CW'(AFULL_LVL);

  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] head;
  logic                  ovf;

  nou_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (retire_rsp_fifo_wr_en),
    .pop   (rv_rsp_fifo_rdy),
    .wdata (retire_rsp_fifo_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .cnt   (rsp_fifo_cnt)
  );

  assign rsp_fifo_retire_full = full;
  assign rsp_fifo_rv_vld      = ~empty;
  assign rsp_fifo_rv_data     = empty ? '0 : head;
  assign rsp_fifo_afull       = (rsp_fifo_cnt >= AF_LVL);
  assign rsp_fifo_ovf         = ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (retire_rsp_fifo_wr_en && full) begin
      ovf <= 1'b1;
    end
  end

`ifdef NOU_RSP_FIFO_IRQ_EN
  localparam logic [CW-1:0] IRQ_LVL = CW'(IRQ_THRESH);

  logic          push_ok;
  logic          pop_ok;
  logic [CW-1:0] cnt_nxt;
  logic          rise;
  logic          ovf_new;
  logic          irq_pend;

  // Look at next occupancy so the flag lands the cycle after the push.
  assign push_ok = retire_rsp_fifo_wr_en & ~full;
  assign pop_ok  = rv_rsp_fifo_rdy & ~empty;
  assign cnt_nxt = rsp_fifo_cnt + CW'(push_ok) - CW'(pop_ok);
  assign rise    = (rsp_fifo_cnt < IRQ_LVL) && (cnt_nxt >= IRQ_LVL);
  assign ovf_new = retire_rsp_fifo_wr_en & full & ~ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_pend <= 1'b0;
    end else if (rise || ovf_new) begin
      irq_pend <= 1'b1;
    end else if (rv_rsp_fifo_irq_clr) begin
      irq_pend <= 1'b0;
    end
  end

  assign rsp_fifo_rv_irq = irq_pend;
`endif

endmodule
